// File: rtl/prescale_counter_if.sv
// Bundle of control inputs and count outputs for prescale_counter.
// There is no valid/ready handshake on this bus: every input is sampled on
// each rising clk edge, load is a single-cycle strobe, and every output is
// registered and valid on every cycle after reset.
interface prescale_counter_if #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
);
    logic                  en;
    logic [PRESCALE_W-1:0] div;
    logic                  dir;
    logic [WIDTH-1:0]      limit;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      q_gray;
    logic                  tc;
    // Prescaler phase, exposed for observation only.
    logic [PRESCALE_W-1:0] pcnt;

    // Controller side: drives configuration, observes the count.
    modport master (
        output en, div, dir, limit, load, load_val,
        input  q, q_gray, tc, pcnt
    );

    // Counter side.
    modport slave (
        input  en, div, dir, limit, load, load_val,
        output q, q_gray, tc, pcnt
    );
endinterface

// File: rtl/prescale_counter.sv
// Counter of configurable width with a clock-enable prescaler, up/down
// direction, programmable wrap limit, synchronous load, a registered
// terminal-count pulse and a registered Gray-coded copy of the count.
module prescale_counter #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    prescale_counter_if.slave    bus
);
    localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PCNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]      cnt_q,  cnt_d;
    logic [WIDTH-1:0]      gray_q, gray_d;
    logic                  tc_q,   tc_d;
    logic                  tick;

    // Tick when the prescaler phase has reached the divisor. Using >= lets a
    // lowered div take effect at once instead of waiting for pcnt to roll over.
    assign tick = bus.en && (pcnt_q >= bus.div);

    // Next-state logic: load beats the enable/tick path; the gray code is
    // always derived from the next count so it can never disagree with q.
    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        if (bus.load) begin
            // A load cancels any tick in the same cycle and restarts the
            // prescaler period. The value is deliberately not clamped.
            cnt_d  = bus.load_val;
            pcnt_d = '0;
        end else if (bus.en) begin
            if (tick) begin
                pcnt_d = '0;
                if (bus.dir) begin
                    // Up: a loaded value above limit also wraps to 0.
                    if (cnt_q >= bus.limit) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    // Down: only 0 wraps; a value above limit just decrements.
                    if (cnt_q == '0) begin
                        cnt_d = bus.limit;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + PCNT_ONE;
            end
        end
        gray_d = cnt_d ^ (cnt_d >> 1);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bus.q      = cnt_q;
    assign bus.q_gray = gray_q;
    assign bus.tc     = tc_q;
    assign bus.pcnt   = pcnt_q;
endmodule

// File: tb/tb_prescale_counter.sv
// Directed bench for prescale_counter: a 32-bit instance driven from a
// vector table and a 4-bit instance exercised by a hand-written wrap run.
module tb_prescale_counter;
    logic clk;
    logic reset;

    prescale_counter_if #(.WIDTH(32), .PRESCALE_W(8)) bus32 ();
    prescale_counter_if #(.WIDTH(4),  .PRESCALE_W(2)) bus4 ();

    prescale_counter #(.WIDTH(32), .PRESCALE_W(8)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    prescale_counter #(.WIDTH(4), .PRESCALE_W(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  div;
        logic        dir;
        logic [31:0] limit;
        logic        load;
        logic [31:0] load_val;
        logic [31:0] exp_q;
        logic        exp_tc;
        logic [7:0]  exp_pcnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] L = 32'hFFFF_FFFF;

    function automatic void v(input logic rst, input logic en, input logic [7:0] dv,
                               input logic dr, input logic [31:0] lim, input logic ld,
                               input logic [31:0] lv, input logic [31:0] eq,
                               input logic etc, input logic [7:0] ep);
        vec_t t;
        t.rst = rst; t.en = en; t.div = dv; t.dir = dr; t.limit = lim;
        t.load = ld; t.load_val = lv; t.exp_q = eq; t.exp_tc = etc; t.exp_pcnt = ep;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gray32(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [3:0] prev_g;
        logic [3:0] exp4;

        reset = 1'b1;
        bus32.en = 1'b0; bus32.div = '0; bus32.dir = 1'b1; bus32.limit = L;
        bus32.load = 1'b0; bus32.load_val = '0;
        bus4.en = 1'b0; bus4.div = '0; bus4.dir = 1'b1; bus4.limit = 4'hF;
        bus4.load = 1'b0; bus4.load_val = '0;

        // Reset state.
        v(1,0,0,1,L,0,0, 0,0,0);
        v(1,0,0,1,L,0,0, 0,0,0);
        // Full-rate up count.
        for (int i = 1; i <= 4; i++) v(0,1,0,1,L,0,0, i,0,0);
        // Half rate, then stall with phase preserved.
        v(1,0,1,1,L,0,0, 0,0,0);
        v(0,1,1,1,L,0,0, 0,0,1);
        v(0,1,1,1,L,0,0, 1,0,0);
        v(0,1,1,1,L,0,0, 1,0,1);
        v(0,1,1,1,L,0,0, 2,0,0);
        v(0,1,1,1,L,0,0, 2,0,1);
        v(0,1,1,1,L,0,0, 3,0,0);
        v(0,1,1,1,L,0,0, 3,0,1);
        for (int i = 0; i < 3; i++) v(0,0,1,1,L,0,0, 3,0,1);
        v(0,1,1,1,L,0,0, 4,0,0);
        v(0,1,1,1,L,0,0, 4,0,1);
        v(0,1,1,1,L,0,0, 5,0,0);
        // Lowering div mid-period ticks at once.
        v(0,1,5,1,L,0,0, 5,0,1);
        v(0,1,5,1,L,0,0, 5,0,2);
        v(0,1,5,1,L,0,0, 5,0,3);
        v(0,1,1,1,L,0,0, 6,0,0);
        // Up wrap at limit 9, then tc cleared by en=0.
        v(1,0,0,1,9,0,0, 0,0,0);
        for (int i = 1; i <= 9; i++) v(0,1,0,1,9,0,0, i,0,0);
        v(0,1,0,1,9,0,0, 0,1,0);
        v(0,0,0,1,9,0,0, 0,0,0);
        v(0,1,0,1,9,0,0, 1,0,0);
        // Down wrap after load.
        v(0,1,0,0,9,1,2, 2,0,0);
        v(0,1,0,0,9,0,0, 1,0,0);
        v(0,1,0,0,9,0,0, 0,0,0);
        v(0,1,0,0,9,0,0, 9,1,0);
        v(0,1,0,0,9,0,0, 8,0,0);
        // Load wins over a tick in the same cycle.
        v(0,1,0,1,9,1,5, 5,0,0);
        v(0,1,0,1,9,0,0, 6,0,0);
        // Load mid-period restarts the prescaler.
        v(0,1,3,1,9,0,0, 6,0,1);
        v(0,1,3,1,9,0,0, 6,0,2);
        v(0,1,3,1,9,1,5, 5,0,0);
        v(0,1,3,1,9,0,0, 5,0,1);
        v(0,1,3,1,9,0,0, 5,0,2);
        v(0,1,3,1,9,0,0, 5,0,3);
        v(0,1,3,1,9,0,0, 6,0,0);
        // Loaded value above limit: up wraps, down decrements.
        v(0,1,0,1,9,1,12, 12,0,0);
        v(0,1,0,1,9,0,0,  0,1,0);
        v(0,1,0,1,9,0,0,  1,0,0);
        v(0,1,0,0,9,1,12, 12,0,0);
        v(0,1,0,0,9,0,0,  11,0,0);
        // Load works while disabled.
        v(0,0,0,1,9,1,3, 3,0,0);
        // Reset mid-run, including one that cancels a wrapping tick.
        v(0,1,0,1,9,1,7, 7,0,0);
        v(1,1,0,1,9,0,0, 0,0,0);
        v(0,1,0,1,9,1,9, 9,0,0);
        v(1,1,0,1,9,0,0, 0,0,0);
        v(0,1,0,1,9,0,0, 1,0,0);
        // Full-range down wrap.
        v(1,0,0,0,L,0,0, 0,0,0);
        v(0,1,0,0,L,0,0, L,1,0);
        v(0,1,0,0,L,0,0, L-32'd1,0,0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset          = vecs[i].rst;
            bus32.en       = vecs[i].en;
            bus32.div      = vecs[i].div;
            bus32.dir      = vecs[i].dir;
            bus32.limit    = vecs[i].limit;
            bus32.load     = vecs[i].load;
            bus32.load_val = vecs[i].load_val;
            @(posedge clk);
            #1;
            check($sformatf("v%0d q", i),      bus32.q,            vecs[i].exp_q);
            check($sformatf("v%0d tc", i),     {31'd0, bus32.tc},  {31'd0, vecs[i].exp_tc});
            check($sformatf("v%0d pcnt", i),   {24'd0, bus32.pcnt}, {24'd0, vecs[i].exp_pcnt});
            check($sformatf("v%0d q_gray", i), bus32.q_gray,       gray32(vecs[i].exp_q));
        end

        // Narrow width: 4-bit full-range up count wraps 15 -> 0 with tc.
        reset = 1'b1;
        bus32.en = 1'b0; bus32.load = 1'b0;
        bus4.en = 1'b1; bus4.div = '0; bus4.dir = 1'b1; bus4.limit = 4'hF; bus4.load = 1'b0;
        @(posedge clk);
        #1;
        check("w4 reset q", {28'd0, bus4.q}, 32'd0);
        check("w4 reset tc", {31'd0, bus4.tc}, 32'd0);
        prev_g = bus4.q_gray;
        reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            exp4 = 4'(i);
            check($sformatf("w4 q%0d", i), {28'd0, bus4.q}, {28'd0, exp4});
            check($sformatf("w4 tc%0d", i), {31'd0, bus4.tc}, 32'd0);
            check($sformatf("w4 gray%0d", i), {28'd0, bus4.q_gray}, {28'd0, exp4 ^ (exp4 >> 1)});
            check($sformatf("w4 onebit%0d", i), $countones(prev_g ^ bus4.q_gray), 32'd1);
            prev_g = bus4.q_gray;
        end
        @(posedge clk);
        #1;
        check("w4 wrap q", {28'd0, bus4.q}, 32'd0);
        check("w4 wrap tc", {31'd0, bus4.tc}, 32'd1);
        check("w4 wrap gray", {28'd0, bus4.q_gray}, 32'd0);
        @(posedge clk);
        #1;
        check("w4 after q", {28'd0, bus4.q}, 32'd1);
        check("w4 after tc", {31'd0, bus4.tc}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
